// File: rtl/decode_stage.sv
// Single-entry decode stage: holds one fetched instruction, decodes it, and issues it
// to register-file/execute once its register, flag and PC-write hazards have cleared.
module decode_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  read_addr_1,
  output logic [3:0]  read_addr_2,
  output logic [3:0]  read_addr_3,
  output logic [3:0]  write_addr,
  output logic        reg_write,
  output logic        link,
  output logic        set_flags,
  output logic        use_imm,
  output logic        branch,
  output logic [3:0]  alu_op,
  output logic [31:0] imm,
  output logic [31:0] out_pc,
  input  logic        flags_we,
  input  logic [3:0]  flags_in,
  input  logic        wb_valid,
  input  logic [3:0]  wb_addr,
  input  logic        flush
);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t      state_q, state_d;
  logic [31:0] instr_q, pc_q;
  logic [3:0]  flags_q;
  logic [14:0] pend_q, pend_d;
  logic        fpend_q, fpend_d;
  logic        blk_q, blk_d;

  logic        full, cond_ok, stall, issue;
  logic        use1, use2, use3;
  logic        src_haz, dst_haz;
  logic [15:0] pend_ext;
  logic [4:0]  rot;
  logic [3:0]  cond;

  // Flags are packed N,Z,C,V from MSB to LSB.
  function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cf, v;
    {n, z, cf, v} = f;
    case (c)
      4'h0:    cond_pass = z;
      4'h1:    cond_pass = !z;
      4'h2:    cond_pass = cf;
      4'h3:    cond_pass = !cf;
      4'h4:    cond_pass = n;
      4'h5:    cond_pass = !n;
      4'h6:    cond_pass = v;
      4'h7:    cond_pass = !v;
      4'h8:    cond_pass = cf && !z;
      4'h9:    cond_pass = !cf || z;
      4'hA:    cond_pass = (n == v);
      4'hB:    cond_pass = (n != v);
      4'hC:    cond_pass = !z && (n == v);
      4'hD:    cond_pass = z || (n != v);
      4'hE:    cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  endfunction

  assign full    = (state_q == FULL);
  assign cond    = instr_q[31:28];
  assign cond_ok = cond_pass(cond, flags_q);
  assign rot     = {instr_q[11:8], 1'b0};

  always_comb begin
    read_addr_1 = '0;
    read_addr_2 = '0;
    read_addr_3 = '0;
    write_addr  = '0;
    reg_write   = 1'b0;
    link        = 1'b0;
    set_flags   = 1'b0;
    use_imm     = 1'b0;
    branch      = 1'b0;
    alu_op      = '0;
    imm         = '0;
    out_pc      = '0;
    use1        = 1'b0;
    use2        = 1'b0;
    use3        = 1'b0;
    if (full) begin
      out_pc = pc_q;
      if (cond_ok) begin
        case (instr_q[27:26])
          2'b00: begin
            alu_op      = instr_q[24:21];
            set_flags   = instr_q[20];
            read_addr_1 = instr_q[19:16];
            write_addr  = instr_q[15:12];
            reg_write   = (instr_q[24:23] != 2'b10);
            // MOV/MVN ignore Rn, so it must not create a false hazard.
            use1        = (instr_q[24:21] != 4'b1101) && (instr_q[24:21] != 4'b1111);
            if (instr_q[25]) begin
              use_imm = 1'b1;
              imm     = {24'd0, instr_q[7:0]} >> rot | {24'd0, instr_q[7:0]} << (6'd32 - {1'b0, rot});
            end else begin
              read_addr_2 = instr_q[3:0];
              use2        = 1'b1;
              if (instr_q[4]) begin
                read_addr_3 = instr_q[11:8];
                use3        = 1'b1;
              end
            end
          end
          2'b10: begin
            branch = 1'b1;
            link   = instr_q[24];
            imm    = {{6{instr_q[23]}}, instr_q[23:0], 2'b00};
          end
          default: ;
        endcase
      end
    end
  end

  // Bit 15 (PC) is never pending, so indexing the extended mask with 15 yields 0.
  assign pend_ext = {1'b0, pend_q};
  assign src_haz  = (use1 && pend_ext[read_addr_1]) ||
                    (use2 && pend_ext[read_addr_2]) ||
                    (use3 && pend_ext[read_addr_3]);
  assign dst_haz  = (reg_write && pend_ext[write_addr]) || (link && pend_q[14]);
  assign stall    = blk_q || src_haz || dst_haz || ((cond != 4'hE) && fpend_q);

  assign out_valid = full && !stall;
  assign issue     = out_valid && out_ready;
  assign in_ready  = !rst && (!full || issue);

  always_comb begin
    state_d = state_q;
    if (flush)                      state_d = EMPTY;
    else if (in_valid && in_ready)  state_d = FULL;
    else if (issue)                 state_d = EMPTY;

    // Set after clear so a same-cycle set and retire leaves the bit pending.
    pend_d = pend_q;
    for (int unsigned i = 0; i < 15; i++) begin
      if (wb_valid && wb_addr == 4'(i))
        pend_d[i] = 1'b0;
      if (issue && ((reg_write && write_addr == 4'(i)) || (link && i == 14)))
        pend_d[i] = 1'b1;
    end

    fpend_d = (issue && set_flags) || (fpend_q && !flags_we);

    blk_d = blk_q;
    if (flush)
      blk_d = 1'b0;
    else if (issue && (branch || (reg_write && write_addr == 4'hF)))
      blk_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      instr_q <= '0;
      pc_q    <= '0;
      flags_q <= '0;
      pend_q  <= '0;
      fpend_q <= 1'b0;
      blk_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      fpend_q <= fpend_d;
      blk_q   <= blk_d;
      if (flags_we)
        flags_q <= flags_in;
      if (in_valid && in_ready && !flush) begin
        instr_q <= in_instr;
        pc_q    <= in_pc;
      end
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: decode fields, hazard stalls, flag-dependent issue,
// branch PC-block with flush, and asynchronous reset behaviour.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [31:0] in_instr, in_pc;
  logic        out_valid, out_ready;
  logic [3:0]  read_addr_1, read_addr_2, read_addr_3, write_addr;
  logic        reg_write, link, set_flags, use_imm, branch;
  logic [3:0]  alu_op;
  logic [31:0] imm, out_pc;
  logic        flags_we;
  logic [3:0]  flags_in;
  logic        wb_valid;
  logic [3:0]  wb_addr;
  logic        flush;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [31:0] ADD1   = 32'hE28210FF; // ADD   r1,r2,#0xFF
  localparam logic [31:0] ADDROT = 32'hE28214FF; // ADD   r1,r2,#0xFF ror 8
  localparam logic [31:0] SUB3   = 32'hE0413004; // SUB   r3,r1,r4
  localparam logic [31:0] ADDS5  = 32'hE2965001; // ADDS  r5,r6,#1
  localparam logic [31:0] ADDEQ7 = 32'h02887002; // ADDEQ r7,r8,#2
  localparam logic [31:0] BLNEG  = 32'hEBFFFFFE; // BL    offset 0xFFFFFE
  localparam logic [31:0] ADD6   = 32'hE28260FF; // ADD   r6,r2,#0xFF

  decode_stage dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .read_addr_1(read_addr_1), .read_addr_2(read_addr_2), .read_addr_3(read_addr_3),
    .write_addr(write_addr), .reg_write(reg_write), .link(link), .set_flags(set_flags),
    .use_imm(use_imm), .branch(branch), .alu_op(alu_op), .imm(imm), .out_pc(out_pc),
    .flags_we(flags_we), .flags_in(flags_in), .wb_valid(wb_valid), .wb_addr(wb_addr),
    .flush(flush)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ADDS followed by ADDEQ; the EQ instruction waits for the flag update, then
  // issues as a real ADD or as a NOP depending on Z.
  task automatic flags_case(input logic [3:0] f, input logic exp_rw);
    in_valid = 1'b1; in_instr = ADDS5; in_pc = 32'h300;
    tick();
    in_instr = ADDEQ7; in_pc = 32'h304;
    #1;
    chk("adds_valid", out_valid, 1);
    chk("adds_set_flags", set_flags, 1);
    tick();
    in_valid = 1'b0;
    #1;
    chk("addeq_flag_stall", out_valid, 0);
    flags_we = 1'b1; flags_in = f;
    #1;
    chk("addeq_stall_same_cycle", out_valid, 0);
    tick();
    flags_we = 1'b0;
    #1;
    chk("addeq_issue", out_valid, 1);
    chk("addeq_reg_write", reg_write, exp_rw);
    chk("addeq_write_addr", write_addr, exp_rw ? 32'd7 : 32'd0);
    chk("addeq_alu_op", alu_op, exp_rw ? 32'd4 : 32'd0);
    chk("addeq_out_pc", out_pc, 32'h304);
    tick();
    wb_valid = 1'b1; wb_addr = 4'd5;
    tick();
    wb_addr = 4'd7;
    tick();
    wb_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_instr = '0; in_pc = '0; out_ready = 1'b0;
    flags_we = 1'b0; flags_in = '0; wb_valid = 1'b0; wb_addr = '0; flush = 1'b0;
    #3;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_imm", imm, 0);
    chk("rst_reg_write", reg_write, 0);
    tick();
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", in_ready, 1);

    // ADD r1,r2,#0xFF then dependent SUB r3,r1,r4
    out_ready = 1'b1;
    in_valid = 1'b1; in_instr = ADD1; in_pc = 32'h100;
    tick();
    in_instr = SUB3; in_pc = 32'h104;
    #1;
    chk("add_valid", out_valid, 1);
    chk("add_alu_op", alu_op, 4'b0100);
    chk("add_ra1", read_addr_1, 2);
    chk("add_wa", write_addr, 1);
    chk("add_imm", imm, 32'h000000FF);
    chk("add_use_imm", use_imm, 1);
    chk("add_reg_write", reg_write, 1);
    chk("add_out_pc", out_pc, 32'h100);
    chk("add_in_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    #1;
    chk("sub_stall", out_valid, 0);
    chk("sub_ra1", read_addr_1, 1);
    chk("sub_ra2", read_addr_2, 4);
    chk("sub_ra3", read_addr_3, 0);
    chk("sub_wa", write_addr, 3);
    chk("sub_alu_op", alu_op, 4'b0010);
    chk("sub_use_imm", use_imm, 0);
    chk("sub_in_ready", in_ready, 0);
    tick();
    chk("sub_stall2", out_valid, 0);
    wb_valid = 1'b1; wb_addr = 4'd1;
    #1;
    chk("sub_stall_wb_cycle", out_valid, 0);
    tick();
    wb_valid = 1'b0;
    #1;
    chk("sub_issue", out_valid, 1);
    chk("sub_out_pc", out_pc, 32'h104);
    tick();
    wb_valid = 1'b1; wb_addr = 4'd3;
    #1;
    chk("empty_after_issue", out_valid, 0);
    chk("empty_in_ready", in_ready, 1);
    tick();
    wb_valid = 1'b0;

    // Rotated immediate, held stable under back-pressure
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = ADDROT; in_pc = 32'h200;
    tick();
    in_valid = 1'b0;
    #1;
    chk("rot_imm", imm, 32'hFF000000);
    chk("rot_valid", out_valid, 1);
    chk("rot_in_ready_bp", in_ready, 0);
    tick();
    chk("rot_imm_stable", imm, 32'hFF000000);
    chk("rot_valid_stable", out_valid, 1);
    out_ready = 1'b1;
    #1;
    chk("rot_in_ready", in_ready, 1);
    tick();
    wb_valid = 1'b1; wb_addr = 4'd1;
    tick();
    wb_valid = 1'b0;

    flags_case(4'b0000, 1'b0);
    flags_case(4'b0100, 1'b1);

    // BL then a held instruction released only by flush
    in_valid = 1'b1; in_instr = BLNEG; in_pc = 32'h400;
    tick();
    in_instr = ADD1; in_pc = 32'h404;
    #1;
    chk("bl_branch", branch, 1);
    chk("bl_link", link, 1);
    chk("bl_imm", imm, 32'hFFFFFFF8);
    chk("bl_reg_write", reg_write, 0);
    chk("bl_valid", out_valid, 1);
    chk("bl_out_pc", out_pc, 32'h400);
    tick();
    in_valid = 1'b0;
    #1;
    chk("pc_block_hold", out_valid, 0);
    chk("pc_block_in_ready", in_ready, 0);
    tick();
    chk("pc_block_hold2", out_valid, 0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    #1;
    chk("flush_empty", out_valid, 0);
    chk("flush_in_ready", in_ready, 1);
    flush = 1'b1; in_valid = 1'b1; in_instr = ADD1; in_pc = 32'h500;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    #1;
    chk("flush_over_load", out_valid, 0);
    wb_valid = 1'b1; wb_addr = 4'd14;
    tick();
    wb_valid = 1'b0;
    in_valid = 1'b1; in_instr = ADD1; in_pc = 32'h600;
    tick();
    in_valid = 1'b0;
    #1;
    chk("block_cleared_issue", out_valid, 1);
    tick();

    // Reset while holding an instruction under back-pressure (r1 pending)
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = ADD6; in_pc = 32'h700;
    tick();
    in_valid = 1'b0;
    #1;
    chk("pre_rst_valid", out_valid, 1);
    chk("pre_rst_wa", write_addr, 6);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_valid", out_valid, 0);
    chk("async_rst_in_ready", in_ready, 0);
    chk("async_rst_wa", write_addr, 0);
    chk("async_rst_out_pc", out_pc, 0);
    tick();
    rst = 1'b0;
    #1;
    chk("rst2_in_ready", in_ready, 1);
    chk("rst2_dropped", out_valid, 0);
    out_ready = 1'b1;
    in_valid = 1'b1; in_instr = SUB3; in_pc = 32'h800;
    tick();
    in_valid = 1'b0;
    #1;
    chk("pend_cleared_by_rst", out_valid, 1);
    tick();
    in_valid = 1'b1; in_instr = ADDEQ7; in_pc = 32'h900;
    tick();
    in_valid = 1'b0;
    #1;
    chk("flags_rst_issue", out_valid, 1);
    chk("flags_rst_nop", reg_write, 0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 SHALL have clk, input, 1, rising-edge clock.
REQ-002 SHALL have rst, input, 1; reset is asynchronous and active-high, on clock clk.
REQ-003 SHALL have in_valid/in_ready, input/output, 1 each: fetch handshake; in_instr input 32 and in_pc input 32 are accepted together.
REQ-004 SHALL have out_valid, output, 1, and out_ready, input, 1: issue handshake to register file/execute.
REQ-005 SHALL have read_addr_1/read_addr_2/read_addr_3, output, 4 each: Rn, Rm, Rs register-file read addresses.
REQ-006 SHALL have write_addr, output, 4, plus reg_write, link, set_flags, use_imm, branch, output, 1 each.
REQ-007 SHALL have alu_op, output, 4; imm, output, 32; out_pc, output, 32.
REQ-008 SHALL have flags_we, input, 1; flags_in, input, 4 (N,Z,C,V from execute).
REQ-009 SHALL have wb_valid, input, 1, and wb_addr, input, 4: register-write retirement from writeback.
REQ-010 SHALL have flush, input, 1: discard held instruction (taken branch / PC write).

Function
REQ-011 SHALL hold one instruction in an output register; state EMPTY or FULL.
REQ-012 SHALL assert in_ready when EMPTY, or FULL and (out_valid and out_ready) in the same cycle.
REQ-013 SHALL load in_instr/in_pc on in_valid and in_ready; decoded outputs appear the next cycle (latency 1).
REQ-014 SHALL drive out_valid = FULL and not stall; outputs SHALL remain stable while out_valid and not out_ready.
REQ-015 SHALL decode class [27:26]: 00 data-processing, 10 branch, other classes as NOP (all enables 0, issued normally).
REQ-016 Data-processing SHALL set alu_op=[24:21], set_flags=[20], read_addr_1=[19:16], write_addr=[15:12], reg_write=1 except alu_op 1000-1011 (compare class, reg_write=0).
REQ-017 With [25]=1 SHALL set use_imm=1, imm = zero-extended [7:0] rotated right by 2*[11:8] in 32 bits.
REQ-018 With [25]=0 SHALL set read_addr_2=[3:0]; when [4]=1 also read_addr_3=[11:8], else read_addr_3=0.
REQ-019 Branch SHALL set branch=1, link=[24], imm = sign-extended [23:0] shifted left 2, reg_write=0.
REQ-020 SHALL hold a 4-bit flags register, loaded from flags_in on flags_we.
REQ-021 SHALL evaluate cond [31:28] per ARM table (0000 EQ .. 1110 AL, 1111 never); a failing condition SHALL issue as NOP with out_pc kept.
REQ-022 SHALL keep a 15-bit pending mask: bit set on issue (out_valid and out_ready) with reg_write and write_addr<=14; bit cleared on wb_valid for wb_addr.
REQ-023 Same-cycle set and clear of one bit SHALL leave it set; set of bit 14 by link SHALL also occur on issue of a linking branch.
REQ-024 SHALL keep flags_pending: set on issue with set_flags, cleared on flags_we; simultaneous SHALL leave it set.
REQ-025 SHALL stall (out_valid=0, instruction held) when any used source address <=14 is pending, when write_addr is pending, or when cond != AL and flags_pending.
REQ-026 Source address 15 (PC) SHALL never stall.
REQ-027 Destination 15 SHALL set no pending bit; issue of write_addr=15 or branch SHALL block further issue until flush.
REQ-028 flush SHALL force EMPTY next cycle, clear the PC-block, and leave pending/flags state intact; flush overrides a simultaneous load.

Reset
REQ-029 rst SHALL immediately force EMPTY, out_valid=0, in_ready=0 while rst high, all decoded outputs 0, flags=0000, pending mask 0, flags_pending 0, PC-block clear.
REQ-030 First cycle after rst deasserts SHALL show in_ready=1; reset mid-handshake SHALL drop the held instruction.

Verification
REQ-031 ADD r1,r2,#0xFF (imm [11:8]=0) with out_ready=1 -> next cycle out_valid=1, alu_op=0100, read_addr_1=2, write_addr=1, imm=0x000000FF, use_imm=1.
REQ-032 Imm 0x4FF -> imm=0xFF000000 (rotate right 8).
REQ-033 Back-to-back ADD r1 then SUB r3,r1,r4 -> second stalls until wb_valid with wb_addr=1, issues the cycle after.
REQ-034 BL offset 0xFFFFFE -> branch=1, link=1, imm=0xFFFFFFF8; next fetched instruction held until flush pulse.
REQ-035 ADDS then ADDEQ -> EQ held until flags_we; flags_in Z=0 -> issues as NOP (reg_write=0).
REQ-036 rst asserted while FULL and out_ready=0 -> out_valid falls without clock edge; pending mask reads 0 after release.
